// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mbist_march_ctrl
// Description : March C- memory BIST controller with a two-stage read-compare
//               pipeline and first-failure capture.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [15:0]           err_cnt
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_prep  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_addr_last = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_ones      = {DATA_WIDTH{1'b1}};

    logic [2:0]            r_state, w_nxt_state;
    logic [2:0]            r_elem, w_nxt_elem;
    logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
    logic                  r_phase, w_nxt_phase;
    logic                  r_drain, w_nxt_drain;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_asc, w_last_op, w_last_addr, w_start_ok;
    logic                  w_nxt_run, w_nxt_wr, w_nxt_lead_ones;

    logic                  r_p1_vld, r_p2_vld;
    logic [DATA_WIDTH-1:0] r_p1_exp, r_p2_exp;
    logic [ADDR_WIDTH-1:0] r_p1_addr, r_p2_addr;
    logic [2:0]            r_p1_elem, r_p2_elem;
    logic                  w_miscmp;

    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [15:0]           r_err_cnt;

    // M3 and M4 walk the array downward; the rest walk upward.
    assign w_asc       = !((r_elem == 3'd3) || (r_elem == 3'd4));
    assign w_last_op   = (r_elem == 3'd0) || (r_elem == 3'd5) || r_phase;
    assign w_last_addr = w_asc ? (r_addr == c_addr_last) : (r_addr == '0);
    assign w_start_ok  = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_elem  = r_elem;
        w_nxt_addr  = r_addr;
        w_nxt_phase = r_phase;
        w_nxt_drain = r_drain;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_nxt_state = c_st_prep;
                    w_nxt_elem  = 3'd0;
                    w_nxt_addr  = '0;
                    w_nxt_phase = 1'b0;
                end
            end
            c_st_prep: w_nxt_state = c_st_run;
            c_st_run: begin
                if (!w_last_op) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    if (!w_last_addr) begin
                        w_nxt_addr = w_asc ? (r_addr + c_addr_one) : (r_addr - c_addr_one);
                    end else if (r_elem == 3'd5) begin
                        w_nxt_state = c_st_drain;
                        w_nxt_addr  = '0;
                        w_nxt_drain = 1'b0;
                    end else begin
                        w_nxt_elem = r_elem + 3'd1;
                        // Descending elements start from the top of the array.
                        w_nxt_addr = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? c_addr_last : '0;
                    end
                end
            end
            c_st_drain: begin
                if (r_drain) w_nxt_state = c_st_done;
                else         w_nxt_drain = 1'b1;
            end
            default: w_nxt_state = c_st_idle;
        endcase
    end

    // The op following a read of M1/M3 is a write of ones; all other writes are zeros.
    assign w_nxt_run       = (w_nxt_state == c_st_run);
    assign w_nxt_wr        = w_nxt_run && ((w_nxt_elem == 3'd0) || (w_nxt_phase && (w_nxt_elem != 3'd5)));
    assign w_nxt_lead_ones = w_nxt_run && !w_nxt_phase && ((w_nxt_elem == 3'd1) || (w_nxt_elem == 3'd3));
    assign w_miscmp        = r_p2_vld && (rdata != r_p2_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_elem      <= 3'd0;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_drain     <= 1'b0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_p1_vld    <= 1'b0;
            r_p1_exp    <= '0;
            r_p1_addr   <= '0;
            r_p1_elem   <= 3'd0;
            r_p2_vld    <= 1'b0;
            r_p2_exp    <= '0;
            r_p2_addr   <= '0;
            r_p2_elem   <= 3'd0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_state   <= w_nxt_state;
            r_elem    <= w_nxt_elem;
            r_addr    <= w_nxt_addr;
            r_phase   <= w_nxt_phase;
            r_drain   <= w_nxt_drain;
            r_wr      <= w_nxt_wr;
            r_wdata   <= w_nxt_lead_ones ? c_ones : '0;
            r_p1_vld  <= w_nxt_run && !w_nxt_wr;
            r_p1_exp  <= ((w_nxt_elem == 3'd2) || (w_nxt_elem == 3'd4)) ? c_ones : '0;
            r_p1_addr <= w_nxt_addr;
            r_p1_elem <= w_nxt_elem;
            r_p2_vld  <= r_p1_vld;
            r_p2_exp  <= r_p1_exp;
            r_p2_addr <= r_p1_addr;
            r_p2_elem <= r_p1_elem;
            if (w_start_ok) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
                r_err_cnt   <= 16'd0;
            end else if (w_miscmp) begin
                r_fail <= 1'b1;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                if (!r_fail) begin
                    r_fail_addr <= r_p2_addr;
                    r_fail_elem <= r_p2_elem;
                end
            end
        end
    end

    assign write_read = r_wr;
    assign address    = r_addr;
    assign wdata      = r_wdata;
    assign busy       = (r_state == c_st_prep) || (r_state == c_st_run) || (r_state == c_st_drain);
    assign done       = (r_state == c_st_done);
    assign fail       = r_fail;
    assign fail_addr  = r_fail_addr;
    assign fail_elem  = r_fail_elem;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbist_march_ctrl
// Description : Scoreboard bench for mbist_march_ctrl with a faultable memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbist_march_ctrl;

    localparam logic [7:0] c_ones = 8'hFF;

    logic        clk, rst, start;
    logic        write_read, busy, done, fail;
    logic [3:0]  address, fail_addr;
    logic [7:0]  wdata, rdata;
    logic [2:0]  fail_elem;
    logic [15:0] err_cnt;

    typedef struct { bit wr; logic [3:0] addr; logic [7:0] wd; bit chk_addr; bit prep; } cyc_t;
    typedef struct { bit fl; logic [3:0] fa; logic [2:0] fe; logic [15:0] ec; } res_t;

    cyc_t opq[$];
    res_t resq[$];
    int   checks = 0, failures = 0;
    int   busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int   fault_mode = 0;
    bit   done_d = 1'b0;
    logic [7:0] mem [16];
    logic [7:0] wd_d;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
        .clk(clk), .rst(rst), .start(start), .write_read(write_read),
        .address(address), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: one-cycle read latency, write data taken from the previous cycle.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
        rdata = 8'h00;
        wd_d  = 8'h00;
    end

    always @(posedge clk) begin
        logic [7:0] v;
        wd_d <= wdata;
        if (write_read) begin
            mem[address] <= wd_d;
        end else begin
            v = mem[address];
            if (fault_mode == 1 && address == 4'd5)  v[3] = 1'b1;
            if (fault_mode == 2 && address == 4'd15) v = 8'h00;
            rdata <= v;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected March C- command stream for one full test plus its final result.
    task automatic push_test(input bit fl, input logic [3:0] fa, input logic [2:0] fe, input logic [15:0] ec);
        cyc_t ops[$];
        cyc_t c;
        res_t r;
        int   a;
        c.chk_addr = 1'b1;
        c.prep     = 1'b0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 16; k++) begin
                a = (e == 3 || e == 4) ? 15 - k : k;
                c.addr = 4'(a);
                if (e != 0) begin
                    c.wr = 1'b0; c.wd = 8'h00; ops.push_back(c);
                end
                if (e < 5) begin
                    c.wr = 1'b1; c.wd = (e == 1 || e == 3) ? c_ones : 8'h00; ops.push_back(c);
                end
            end
        end
        c.wr = 1'b0; c.addr = 4'd0; c.prep = 1'b1;
        c.wd = ops[0].wr ? ops[0].wd : 8'h00;
        opq.push_back(c);
        for (int i = 0; i < ops.size(); i++) begin
            c = ops[i];
            c.wd = (i + 1 < ops.size() && ops[i+1].wr) ? ops[i+1].wd : 8'h00;
            opq.push_back(c);
        end
        c.wr = 1'b0; c.addr = 4'd0; c.wd = 8'h00; c.chk_addr = 1'b0; c.prep = 1'b0;
        opq.push_back(c);
        opq.push_back(c);
        r.fl = fl; r.fa = fa; r.fe = fe; r.ec = ec;
        resq.push_back(r);
    endtask

    // Monitor: per-cycle command checks while busy, result checks when done rises.
    always @(negedge clk) begin
        cyc_t c;
        res_t r;
        if (busy) begin
            busy_cnt++;
            if (write_read) wr_cnt++; else rd_cnt++;
            if (opq.size() == 0) begin
                checks++; failures++;
                $display("FAIL op_underflow actual=busy expected=no_command at %0t", $time);
            end else begin
                c = opq.pop_front();
                chk("write_read", write_read, c.wr);
                if (c.chk_addr) chk("address", address, c.addr);
                chk("wdata", wdata, c.wd);
                if (c.prep) begin
                    chk("prep_fail", fail, 0);
                    chk("prep_err_cnt", err_cnt, 0);
                    chk("prep_done", done, 0);
                end
            end
        end
        if (done && !done_d) begin
            if (resq.size() == 0) begin
                checks++; failures++;
                $display("FAIL res_underflow actual=done expected=no_result at %0t", $time);
            end else begin
                r = resq.pop_front();
                chk("busy_cycles", busy_cnt, 163);
                chk("write_count", wr_cnt, 80);
                chk("read_count", rd_cnt - 3, 80);
                chk("fail", fail, r.fl);
                if (r.fl) begin
                    chk("fail_addr", fail_addr, r.fa);
                    chk("fail_elem", fail_elem, r.fe);
                end
                chk("err_cnt", err_cnt, r.ec);
                chk("busy_at_done", busy, 0);
            end
            busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        end
        done_d = done;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
        end
        @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write_read"}, write_read, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_fail_addr"}, fail_addr, 0);
        chk({tag, "_fail_elem"}, fail_elem, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk) begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        // Fault-free run, then done must stay held.
        push_test(1'b0, 4'd0, 3'd0, 16'd0);
        pulse_start();
        wait_done();
        repeat (5) @(negedge clk);
        chk("done_held", done, 1);
        chk("done_held_busy", busy, 0);

        // Bit 3 of address 5 stuck-at-1: caught in M1, M3, M5.
        fault_mode = 1;
        push_test(1'b1, 4'd5, 3'd1, 16'd3);
        pulse_start();
        wait_done();

        // Whole word at address 15 stuck-at-0: caught in M2 and M4.
        fault_mode = 2;
        push_test(1'b1, 4'd15, 3'd2, 16'd2);
        pulse_start();
        wait_done();

        // A start pulse while running must not disturb the sequence.
        fault_mode = 0;
        push_test(1'b0, 4'd0, 3'd0, 16'd0);
        pulse_start();
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();

        // Reset in the middle of M3, then a clean restart.
        push_test(1'b0, 4'd0, 3'd0, 16'd0);
        pulse_start();
        repeat (95) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        opq.delete();
        resq.delete();
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        @(negedge clk) chk_all_zero("midrun_reset");
        push_test(1'b0, 4'd0, 3'd0, 16'd0);
        pulse_start();
        wait_done();

        // Reset and start together: reset wins, block stays idle.
        @(posedge clk); #1 begin rst = 1'b1; start = 1'b1; end
        @(posedge clk); #1 begin rst = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk) begin
            chk("collide_busy", busy, 0);
            chk("collide_done", done, 0);
        end

        repeat (2) @(posedge clk);
        chk("opq_empty", opq.size(), 0);
        chk("resq_empty", resq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
